alu_op_dispatch: RTL and testbench

- Demultiplexing dispatcher for the 4-bit ALU datapath. It accepts one operation request per cycle on a valid/ready input stream and routes the operand pair to one of four functional-unit channels (ADD, SUB, AND, OR), selected by a 2-bit opcode.
- Each channel has its own one-entry output register with a valid/ready handshake, so the channels drain independently.
- It keeps a saturating per-channel dispatch counter for debug and performance visibility.
- It sits upstream of the functional units, in the opposite direction to the result-select mux.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_chan_buf.sv | 41 ++++
 rtl/alu_op_dispatch.sv | 40 ++++
 tb/tb_alu_op_dispatch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum, channel count and per-channel buffer state for the ALU datapath
package alu_pkg;
  localparam int NUM_CH = 4;
  typedef enum logic [1:0] {
    SEL_ADD = 2'd0,
    SEL_SUB = 2'd1,
    SEL_AND = 2'd2,
    SEL_OR  = 2'd3
  } alu_sel_e;
  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;
endpackage

// File: rtl/alu_chan_buf.sv
// alu_chan_buf: one-entry valid/ready operand register plus saturating load counter (in: load_i/a_i/b_i/out_ready_i/cnt_clr_i, out: out_valid_o/out_a_o/out_b_o/cnt_o)
module alu_chan_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             out_ready_i,
  input  logic             cnt_clr_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic [CNT_W-1:0] cnt_o
);
  ch_state_e        state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= CH_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= load_i ? CH_FULL : (out_ready_i ? CH_EMPTY : state_q);
      if (load_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      cnt_q <= cnt_clr_i ? '0 : cnt_q + CNT_W'(load_i && cnt_q != '1);
    end
  assign out_valid_o = state_q == CH_FULL;
  assign out_a_o     = a_q;
  assign out_b_o     = b_q;
  assign cnt_o       = cnt_q;
endmodule

// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch: routes one operand pair per cycle to one of four channel buffers by opcode (in: in_valid/in_sel/in_a/in_b/out_ready/cnt_clr, out: in_ready/out_valid/out_a/out_b/cnt)
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_sel,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_a,
  output logic [NUM_CH*WIDTH-1:0] out_b,
  input  logic                    cnt_clr,
  output logic [NUM_CH*CNT_W-1:0] cnt
);
  alu_sel_e sel;
  assign sel      = alu_sel_e'(in_sel);
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alu_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .load_i      (in_valid && in_ready && sel == alu_sel_e'(2'(i))),
      .a_i         (in_a),
      .b_i         (in_b),
      .out_ready_i (out_ready[i]),
      .cnt_clr_i   (cnt_clr),
      .out_valid_o (out_valid[i]),
      .out_a_o     (out_a[i*WIDTH +: WIDTH]),
      .out_b_o     (out_b[i*WIDTH +: WIDTH]),
      .cnt_o       (cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_alu_op_dispatch.sv
// tb_alu_op_dispatch: scoreboard-driven scenario bench for alu_op_dispatch
module tb_alu_op_dispatch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = '0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [15:0] out_a, out_b;
  logic        cnt_clr = 1'b0;
  logic [31:0] cnt;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb [4][$];
  logic [7:0]  exp_cnt [4];
  logic [7:0]  exp_ab;
  alu_op_dispatch #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        sb[c].delete();
        exp_cnt[c] = 8'd0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (cnt[c*8 +: 8] !== exp_cnt[c]) begin
          failures++;
          $display("FAIL sb_cnt%0d got=%0d exp=%0d", c, cnt[c*8 +: 8], exp_cnt[c]);
        end
        if (out_valid[c] && out_ready[c]) begin
          checks++;
          if (sb[c].size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected ch%0d got a=%0d b=%0d exp none", c, out_a[c*4 +: 4], out_b[c*4 +: 4]);
          end else begin
            exp_ab = sb[c].pop_front();
            if ({out_a[c*4 +: 4], out_b[c*4 +: 4]} !== exp_ab) begin
              failures++;
              $display("FAIL sb_data ch%0d got a=%0d b=%0d exp a=%0d b=%0d", c, out_a[c*4 +: 4], out_b[c*4 +: 4], exp_ab[7:4], exp_ab[3:0]);
            end
          end
        end
        if (cnt_clr) exp_cnt[c] = 8'd0;
        else if (in_valid && in_ready && in_sel == 2'(c) && exp_cnt[c] != 8'd255) exp_cnt[c] = exp_cnt[c] + 8'd1;
      end
      if (in_valid && in_ready) sb[in_sel].push_back({in_a, in_b});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if ({out_a, out_b} !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {out_a, out_b}); end
    cyc();
  endtask
  task automatic test_basic();
    out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd2; in_a = 4'd5; in_b = 4'd3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL basic_valid got=%b exp=0100", out_valid); end
    checks++; if (out_a[11:8] !== 4'd5 || out_b[11:8] !== 4'd3) begin failures++; $display("FAIL basic_data got a=%0d b=%0d exp a=5 b=3", out_a[11:8], out_b[11:8]); end
    checks++; if (cnt[23:16] !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", cnt[23:16]); end
    cyc();
  endtask
  task automatic test_stall();
    out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd0; in_a = 4'd1; in_b = 4'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_first_ready got=%b exp=1", in_ready); end
    cyc();
    in_a = 4'd2; in_b = 4'd2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid[0] !== 1'b1 || out_a[3:0] !== 4'd1) begin failures++; $display("FAIL stall_hold got v=%b a=%0d exp v=1 a=1", out_valid[0], out_a[3:0]); end
      cyc();
    end
    out_ready = 4'b0001;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0; out_ready = 4'h0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0001 || out_a[3:0] !== 4'd2 || out_b[3:0] !== 4'd2) begin failures++; $display("FAIL stall_next got v=%b a=%0d b=%0d exp v=0001 a=2 b=2", out_valid, out_a[3:0], out_b[3:0]); end
    cyc();
    out_ready = 4'hF;
    cyc();
  endtask
  task automatic test_back_to_back();
    logic [1:0] prev;
    out_ready = 4'hF; in_valid = 1'b1; prev = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_sel = (k % 2 == 0) ? 2'd1 : 2'd3; in_a = 4'(k + 8); in_b = 4'(k + 1);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, in_ready); end
      if (k > 0) begin
        checks++; if (out_valid !== 4'(1 << prev)) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, out_valid, 4'(1 << prev)); end
      end
      prev = in_sel;
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b1000) begin failures++; $display("FAIL b2b_last got=%b exp=1000", out_valid); end
    checks++; if (cnt[15:8] !== 8'd2 || cnt[31:24] !== 8'd2) begin failures++; $display("FAIL b2b_cnt got c1=%0d c3=%0d exp 2 2", cnt[15:8], cnt[31:24]); end
    cyc();
  endtask
  task automatic test_hol();
    out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd3; in_a = 4'd7; in_b = 4'd8;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_fill_ready got=%b exp=1", in_ready); end
    cyc();
    in_a = 4'd9; in_b = 4'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hol_blocked got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 4'b1000 || out_a[15:12] !== 4'd7) begin failures++; $display("FAIL hol_hold got v=%b a=%0d exp v=1000 a=7", out_valid, out_a[15:12]); end
      cyc();
    end
    out_ready = 4'b1000;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hol_release got=%b exp=1", in_ready); end
    cyc();
    in_sel = 2'd0; in_a = 4'd4; in_b = 4'd4;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid[0] !== 1'b0) begin failures++; $display("FAIL hol_ch0_pending got r=%b v0=%b exp r=1 v0=0", in_ready, out_valid[0]); end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid[0] !== 1'b1 || out_a[3:0] !== 4'd4) begin failures++; $display("FAIL hol_ch0_out got v0=%b a=%0d exp v0=1 a=4", out_valid[0], out_a[3:0]); end
    cyc();
    out_ready = 4'hF;
    cyc();
  endtask
  task automatic test_saturation();
    out_ready = 4'hF; in_valid = 1'b1; in_sel = 2'd2;
    for (int k = 0; k < 260; k++) begin
      in_a = 4'(k); in_b = 4'(k >> 4);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt[23:16] !== 8'd255) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", cnt[23:16]); end
    cyc();
    cnt_clr = 1'b1; in_valid = 1'b1; in_a = 4'd6; in_b = 4'd9;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clr_ready got=%b exp=1", in_ready); end
    cyc();
    cnt_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt !== 32'd0) begin failures++; $display("FAIL clr_cnt got=%h exp=0", cnt); end
    cyc();
  endtask
  task automatic test_async_reset();
    out_ready = 4'h0; in_valid = 1'b1; in_sel = 2'd0; in_a = 4'hA; in_b = 4'hB;
    cyc();
    in_sel = 2'd1; in_a = 4'hC; in_b = 4'hD;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0011) begin failures++; $display("FAIL arst_pre got=%b exp=0011", out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL arst_valid got=%b exp=0000", out_valid); end
    checks++; if ({out_a, out_b} !== 32'd0) begin failures++; $display("FAIL arst_data got=%h exp=0", {out_a, out_b}); end
    @(negedge clk);
    cyc();
    rst = 1'b0; out_ready = 4'hF;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 4'b0000 || cnt !== 32'd0) begin failures++; $display("FAIL arst_after got r=%b v=%b cnt=%h exp r=1 v=0000 cnt=0", in_ready, out_valid, cnt); end
    cyc();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_hol();
    test_saturation();
    test_async_reset();
    for (int c = 0; c < 4; c++) begin
      checks++; if (sb[c].size() != 0) begin failures++; $display("FAIL sb_leftover ch%0d got=%0d exp=0", c, sb[c].size()); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
